timer_ctrl: RTL and testbench

Control FSM that sequences the countdown timer datapath (hr:min:sec:ms, 23:59:59:999 preset).
- Conditions raw start/stop and clear buttons.
- Generates the 1 ms decrement enable from clk.
- Issues preset loads, detects expiry and drives a timed alarm.
- Sits between the board buttons and the timer datapath; the datapath only decrements when dec_en is high and loads its preset when load is high.

---
 rtl/timer_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 44 ++++
 rtl/timer_ctrl.sv | 136 +++++++++++++
 tb/tb_timer_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: controller state encoding and
// the packed hr:min:sec:ms preset layout used by the datapath.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        EXPIRED = 2'b11
    } timer_state_t;

    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;
    localparam int SEC_MAX = 59;
    localparam int MS_MAX  = 999;

    localparam int HR_W     = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;
    localparam int MS_W     = 10;
    localparam int PRESET_W = HR_W + MIN_W + SEC_W + MS_W;

    function automatic logic [PRESET_W-1:0] preset_value();
        return {HR_W'(HR_MAX), MIN_W'(MIN_MAX), SEC_W'(SEC_MAX), MS_W'(MS_MAX)};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level counter and a one-cycle
// pulse on each accepted press (releases are accepted silently).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          level, level_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            rise    <= level & ~level_d;
            // Any sample matching the accepted level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller: button conditioning, 1 ms tick, preset loads,
// expiry detection and timed alarm. Lap/hold support built with TIMER_CTRL_LAP_EN.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_HZ          = 100000000,
    parameter int TICK_HZ         = 1000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ALARM_MS        = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic       at_zero,
    output logic       load,
    output logic       dec_en,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state,
    output logic       hold
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam int AW  = (ALARM_MS > 1) ? $clog2(ALARM_MS) : 1;
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_MS - 1);
    localparam logic ALARM_ON = (ALARM_MS != 0);

    timer_state_t  st, nxt;
    logic          ss_p, clr_p;
    logic [PW-1:0] presc;
    logic          presc_en, wrap, tick;
    logic [AW-1:0] acnt;
    logic          por_done;
    logic          enter_expired;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk(clk), .reset(reset), .raw(btn_start_stop), .rise(ss_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(clk), .reset(reset), .raw(btn_clear), .rise(clr_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) st <= IDLE;
        else       st <= nxt;
    end

    always_comb begin
        nxt = st;
        if (clr_p) begin
            nxt = IDLE;
        end else begin
            case (st)
                IDLE:    if (ss_p) nxt = at_zero ? EXPIRED : RUNNING;
                RUNNING: if (at_zero) nxt = EXPIRED;
                         else if (ss_p) nxt = PAUSED;
                PAUSED:  if (ss_p) nxt = RUNNING;
                default: nxt = st;
            endcase
        end
    end

    assign enter_expired = (nxt == EXPIRED) && (st != EXPIRED);

    // Prescaler restarts from 0 on every entry to a counting state, so the
    // first tick lands a full DIV cycles later.
    assign presc_en = ((st == RUNNING) && (nxt == RUNNING)) ||
                      ((st == EXPIRED) && (nxt == EXPIRED) && alarm);
    assign wrap     = presc_en && (presc == PRE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= wrap;
            if (!presc_en || wrap) presc <= '0;
            else                   presc <= presc + 1'b1;
        end
    end

    assign dec_en = tick && (st == RUNNING) && !at_zero;
    assign state  = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            por_done <= 1'b0;
            load     <= 1'b0;
            running  <= 1'b0;
            alarm    <= 1'b0;
            acnt     <= '0;
        end else begin
            por_done <= 1'b1;
            load     <= !por_done || clr_p;
            running  <= (nxt == RUNNING);
            if (clr_p) begin
                alarm <= 1'b0;
                acnt  <= '0;
            end else if (enter_expired) begin
                alarm <= ALARM_ON;
                acnt  <= '0;
            end else if (alarm && wrap) begin
                if (acnt == ALARM_LAST) begin
                    alarm <= 1'b0;
                    acnt  <= '0;
                end else begin
                    acnt <= acnt + 1'b1;
                end
            end
        end
    end

`ifdef TIMER_CTRL_LAP_EN
    logic lap_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk(clk), .reset(reset), .raw(btn_lap), .rise(lap_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                       hold <= 1'b0;
        else if (clr_p || enter_expired)                 hold <= 1'b0;
        else if (lap_p && (st == RUNNING || st == PAUSED)) hold <= ~hold;
    end
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign hold       = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with DIV=10, DEBOUNCE_CYCLES=4, ALARM_MS=3.
// Lap expectations follow TIMER_CTRL_LAP_EN.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start_stop = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap = 1'b0;
    logic       at_zero = 1'b0;
    logic       load, dec_en, running, alarm, hold;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    timer_ctrl #(
        .CLK_HZ(10000), .TICK_HZ(1000), .DEBOUNCE_CYCLES(4), .ALARM_MS(3)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_start_stop(btn_start_stop), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .at_zero(at_zero),
        .load(load), .dec_en(dec_en), .running(running), .alarm(alarm),
        .state(state), .hold(hold)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn_start_stop = 1'b0;
        btn_clear = 1'b0;
        btn_lap = 1'b0;
        at_zero = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int dec_seen;
        reset = 1'b1;
        step();
        step();
        checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", state); end
        checks++; if (load !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", load); end
        checks++; if (dec_en !== 1'b0) begin failures++; $display("FAIL reset_dec_en got=%b exp=0", dec_en); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
        checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
        checks++; if (hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", hold); end
        reset = 1'b0;
        step();
        checks++; if (load !== 1'b1) begin failures++; $display("FAIL por_load_first got=%b exp=1", load); end
        checks++; if (state !== 2'b00) begin failures++; $display("FAIL por_state got=%b exp=00", state); end
        dec_seen = 0;
        for (int i = 2; i <= 101; i++) begin
            step();
            if (dec_en === 1'b1) dec_seen++;
            checks++; if (load !== 1'b0) begin failures++; $display("FAIL por_load_once cyc=%0d got=%b exp=0", i, load); end
        end
        checks++; if (dec_seen !== 0) begin failures++; $display("FAIL idle_no_dec got=%0d exp=0", dec_seen); end
        checks++; if (state !== 2'b00) begin failures++; $display("FAIL idle_stays got=%b exp=00", state); end
    endtask

    task automatic test_start();
        logic [1:0] exp_st;
        logic       exp_dec;
        do_reset();
        btn_start_stop = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            exp_st  = (i >= 8) ? 2'b01 : 2'b00;
            exp_dec = (i >= 18) && ((i - 18) % 10 == 0);
            checks++; if (state !== exp_st) begin failures++; $display("FAIL start_state cyc=%0d got=%b exp=%b", i, state, exp_st); end
            checks++; if (running !== (exp_st == 2'b01)) begin failures++; $display("FAIL start_running cyc=%0d got=%b exp=%b", i, running, exp_st == 2'b01); end
            checks++; if (dec_en !== exp_dec) begin failures++; $display("FAIL start_dec_en cyc=%0d got=%b exp=%b", i, dec_en, exp_dec); end
            if (i == 10) btn_start_stop = 1'b0;
        end
        // Asynchronous reset takes effect before the next clock edge.
        reset = 1'b1;
        #2;
        checks++; if (state !== 2'b00) begin failures++; $display("FAIL async_reset_state got=%b exp=00", state); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL async_reset_running got=%b exp=0", running); end
        reset = 1'b0;
    endtask

    task automatic test_pause_glitch();
        logic [1:0] exp_st;
        logic       exp_dec;
        do_reset();
        btn_start_stop = 1'b1;
        for (int i = 1; i <= 95; i++) begin
            step();
            if (i < 8)       exp_st = 2'b00;
            else if (i < 48) exp_st = 2'b01;
            else if (i < 68) exp_st = 2'b10;
            else             exp_st = 2'b01;
            exp_dec = ((i >= 18) && (i < 48) && ((i - 18) % 10 == 0)) ||
                      ((i >= 78) && ((i - 78) % 10 == 0));
            checks++; if (state !== exp_st) begin failures++; $display("FAIL pause_state cyc=%0d got=%b exp=%b", i, state, exp_st); end
            checks++; if (dec_en !== exp_dec) begin failures++; $display("FAIL pause_dec_en cyc=%0d got=%b exp=%b", i, dec_en, exp_dec); end
            btn_start_stop = (i < 10) || (i >= 30 && i < 33) || (i >= 40 && i < 50) || (i >= 60 && i < 70);
        end
    endtask

    task automatic test_expiry();
        logic [1:0] exp_st;
        logic       exp_alarm;
        int         alarm_cycles;
        do_reset();
        btn_start_stop = 1'b1;
        alarm_cycles = 0;
        for (int i = 1; i <= 90; i++) begin
            step();
            if (i < 8)       exp_st = 2'b00;
            else if (i < 26) exp_st = 2'b01;
            else             exp_st = 2'b11;
            exp_alarm = (i >= 26) && (i < 56);
            if (alarm === 1'b1) alarm_cycles++;
            checks++; if (state !== exp_st) begin failures++; $display("FAIL expiry_state cyc=%0d got=%b exp=%b", i, state, exp_st); end
            checks++; if (alarm !== exp_alarm) begin failures++; $display("FAIL expiry_alarm cyc=%0d got=%b exp=%b", i, alarm, exp_alarm); end
            checks++; if (dec_en !== (i == 18)) begin failures++; $display("FAIL expiry_dec_en cyc=%0d got=%b exp=%b", i, dec_en, i == 18); end
            btn_start_stop = (i < 10) || (i >= 60 && i < 70);
            if (i == 25) at_zero = 1'b1;
        end
        checks++; if (alarm_cycles !== 30) begin failures++; $display("FAIL alarm_length got=%0d exp=30", alarm_cycles); end
    endtask

    task automatic test_clear_vs_start();
        logic [1:0] exp_st;
        do_reset();
        btn_start_stop = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step();
            exp_st = (i >= 8 && i < 28) ? 2'b01 : 2'b00;
            checks++; if (state !== exp_st) begin failures++; $display("FAIL clr_ss_state cyc=%0d got=%b exp=%b", i, state, exp_st); end
            if (i >= 2) begin
                checks++; if (load !== (i == 28)) begin failures++; $display("FAIL clr_ss_load cyc=%0d got=%b exp=%b", i, load, i == 28); end
            end
            checks++; if (alarm !== 1'b0) begin failures++; $display("FAIL clr_ss_alarm cyc=%0d got=%b exp=0", i, alarm); end
            checks++; if (dec_en !== (i == 18)) begin failures++; $display("FAIL clr_ss_dec_en cyc=%0d got=%b exp=%b", i, dec_en, i == 18); end
            btn_start_stop = (i < 10) || (i >= 20 && i < 30);
            btn_clear      = (i >= 20 && i < 30);
        end
    endtask

    task automatic test_idle_zero_clear();
        logic [1:0] exp_st;
        logic       exp_alarm;
        do_reset();
        at_zero = 1'b1;
        btn_start_stop = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            exp_st    = (i >= 8 && i < 18) ? 2'b11 : 2'b00;
            exp_alarm = (i >= 8 && i < 18);
            checks++; if (state !== exp_st) begin failures++; $display("FAIL zero_state cyc=%0d got=%b exp=%b", i, state, exp_st); end
            checks++; if (alarm !== exp_alarm) begin failures++; $display("FAIL zero_alarm cyc=%0d got=%b exp=%b", i, alarm, exp_alarm); end
            if (i >= 2) begin
                checks++; if (load !== (i == 18)) begin failures++; $display("FAIL zero_load cyc=%0d got=%b exp=%b", i, load, i == 18); end
            end
            btn_start_stop = (i < 10);
            btn_clear      = (i >= 10 && i < 20);
        end
    endtask

    task automatic test_lap();
        logic [1:0] exp_st;
        logic       exp_hold, exp_dec;
        do_reset();
        btn_start_stop = 1'b1;
        for (int i = 1; i <= 85; i++) begin
            step();
            if (i < 8)       exp_st = 2'b00;
            else if (i < 76) exp_st = 2'b01;
            else             exp_st = 2'b11;
`ifdef TIMER_CTRL_LAP_EN
            exp_hold = (i >= 28 && i < 48) || (i >= 68 && i < 76);
`else
            exp_hold = 1'b0;
`endif
            exp_dec = (i >= 18) && (i < 76) && ((i - 18) % 10 == 0);
            checks++; if (state !== exp_st) begin failures++; $display("FAIL lap_state cyc=%0d got=%b exp=%b", i, state, exp_st); end
            checks++; if (hold !== exp_hold) begin failures++; $display("FAIL lap_hold cyc=%0d got=%b exp=%b", i, hold, exp_hold); end
            checks++; if (dec_en !== exp_dec) begin failures++; $display("FAIL lap_dec_en cyc=%0d got=%b exp=%b", i, dec_en, exp_dec); end
            btn_start_stop = (i < 10);
            btn_lap = (i >= 20 && i < 30) || (i >= 40 && i < 50) || (i >= 60 && i < 70);
            if (i == 75) at_zero = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_pause_glitch();
        test_expiry();
        test_clear_vs_start();
        test_idle_zero_clear();
        test_lap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
